// File: rtl/mod_count_sequencer.sv
// Run/pause/step controller for a modulo counter with a run-time modulus and lap target.
// Reports each wrap-around and pulses done when the requested number of laps completes.
module mod_count_sequencer #(
  parameter int WIDTH       = 4,
  parameter int LAP_W       = 4,
  parameter int DEFAULT_MOD = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             step,
  input  logic [WIDTH-1:0] mod_val,
  input  logic [LAP_W-1:0] laps,
  output logic [WIDTH-1:0] count,
  output logic [LAP_W-1:0] lap_count,
  output logic             wrap,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [WIDTH-1:0] MOD_DEFAULT  = WIDTH'(DEFAULT_MOD);
  localparam logic [WIDTH-1:0] MOD_USE_DEF  = '1;

  state_t           state;
  logic [WIDTH-1:0] mod_r;
  logic [LAP_W-1:0] laps_r;
  logic [WIDTH-1:0] last;
  logic [LAP_W-1:0] lap_next;
  logic             at_top;
  logic             hit;
  logic             adv;

  // mod_r is never 0 once latched, so mod_r-1 stays inside WIDTH bits.
  always_comb begin
    last     = mod_r - WIDTH'(1);
    at_top   = (count == last);
    lap_next = lap_count + LAP_W'(1);
    hit      = (laps_r != '0) && (lap_next == laps_r);
    adv      = ((state == RUN)   && !stop && !pause) ||
               ((state == PAUSE) && !stop &&  pause && step);
  end

  // NOTE: state registers use non-blocking assignments so every read in this
  // block sees the pre-edge value, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      lap_count <= '0;
      mod_r     <= MOD_DEFAULT;
      laps_r    <= '0;
      wrap      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wrap <= 1'b0;
      done <= 1'b0;
      err  <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            if (mod_val == '0) begin
              err <= 1'b1;
            end else begin
              mod_r     <= (mod_val == MOD_USE_DEF) ? MOD_DEFAULT : mod_val;
              laps_r    <= laps;
              count     <= '0;
              lap_count <= '0;
              state     <= RUN;
              busy      <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (pause) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (stop) begin
            state <= IDLE;
            count <= '0;
            busy  <= 1'b0;
          end else if (!pause) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          if (stop) count <= '0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // adv already excludes stop and pause transitions, so this never
      // competes with the state changes above except for reaching DONE.
      if (adv) begin
        if (at_top) begin
          count     <= '0;
          wrap      <= 1'b1;
          lap_count <= lap_next;
          if (hit) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end else begin
          count <= count + WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: doc/mod_count_sequencer.md
# mod_count_sequencer

Controller that sequences a modulo counter datapath: it accepts a start command with a run-time modulus and lap count, then runs, pauses, single-steps and stops the count. It reports each wrap-around and signals completion after the requested number of laps. It sits between control/debug logic (buttons, step/run control of the single-cycle core) and the count-consuming logic (display scan, timing ticks).

## Interface
- WIDTH, 4: count and modulus width.
- LAP_W, 4: lap counter and lap-target width.
- DEFAULT_MOD, 12: modulus used when `mod_val` is sampled as all-ones (the "use default" code).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  start command, sampled only in IDLE.
- stop  in  1  abort command, sampled in every non-IDLE state.
- pause  in  1  level: hold count while high (RUN/PAUSE only).
- step  in  1  single-count advance, sampled only in PAUSE.
- mod_val  in  WIDTH  modulus, latched on accepted start.
- laps  in  LAP_W  lap target, latched on accepted start; 0 = run until stop.
- count  out  WIDTH  current count, range 0..mod-1.
- lap_count  out  LAP_W  completed laps since start, wraps at 2^LAP_W.
- wrap  out  1  one-cycle pulse: count returned to 0 from mod-1.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse: lap target reached.
- err  out  1  one-cycle pulse: start rejected (mod_val == 0).

## Operation
- States: IDLE, RUN, PAUSE, DONE. Reset: state IDLE, count 0, lap_count 0, wrap/done/err/busy 0, latched modulus DEFAULT_MOD, latched laps 0.
- IDLE: start with mod_val == 0 → err = 1 for one cycle, stay IDLE. Start with mod_val != 0 → latch mod (all-ones → DEFAULT_MOD), latch laps, count 0, lap_count 0, go to RUN. start is ignored in every other state.
- Advance (RUN each cycle with pause low, or PAUSE on step): if count == mod-1, then count ← 0, wrap ← 1 and lap_count ← lap_count+1. Otherwise count ← count+1. The count comparison is done at WIDTH bits and never exceeds mod-1.
- Mod == 1: count stays 0 and wrap pulses on every advance.
- Lap target: if laps != 0 and lap_count+1 == laps on a wrapping advance → go to DONE. That same edge sets done = 1 and wrap = 1, and count = 0.
- Laps == 0: lap_count free-runs and wraps 2^LAP_W-1 → 0. done never fires.
- RUN with pause high → PAUSE. No advance happens on that edge.
- PAUSE with pause low → RUN. No advance happens on that edge, even if step is high.
- PAUSE with pause high and step high → one advance per cycle step is high. The block stays in PAUSE, or goes to DONE if the target is reached.
- DONE → IDLE unconditionally on the next edge. count and lap_count hold their final values.
- stop in RUN/PAUSE/DONE → IDLE, count 0, no wrap/done pulse, lap_count holds.
- Priority: rst > stop > lap-target/DONE > pause/step > advance.

## Timing
- All outputs registered. wrap, done and err are high exactly one cycle.
- Start accepted at edge t0: after t0 busy = 1 and count = 0. After t0+n (no pause), count = n mod M.
- First wrap at edge t0+M. DONE is entered at edge t0+M·laps, with done = 1 in that cycle. busy drops after edge t0+M·laps+1.
- stop at edge ts: count = 0 and busy = 0 after ts.
- stop coinciding with a wrapping advance: stop wins. No wrap pulse, and no lap increment.
- Pause entry/exit costs one non-advancing edge each.
- rst mid-operation: all state returns to reset values on that edge. Inputs in the same cycle are ignored.

## Test plan
- Reset then start, mod_val=12, laps=2, no pause → count 0..11 twice; wrap at t0+12 and t0+24; done at t0+24 with lap_count=2; busy low after t0+25.
- start with mod_val=0 → err pulse one cycle, busy stays 0, count 0. Start with mod_val=4'hF → modulus 12 (wrap every 12 cycles).
- RUN mod=5 laps=0; pause high at count=3 → count holds 3. Three step pulses → 4, 0 (wrap, lap 1), 1. Pause low → resumes 2,3… after one idle edge.
- mod=1 laps=3 → wrap every cycle, done at t0+3, count always 0.
- mod=6 laps=0 run 30 cycles, assert stop on the cycle where count=5 → next cycle IDLE, count 0, no wrap, lap_count=4; a start issued in RUN earlier is ignored.
- rst asserted mid-RUN at count=7 with start and step high → all outputs at reset values next cycle, state IDLE.
